// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register with one-hot DR chain select, built-in IDCODE.
// Latency: chain strobes are combinational from the TAP state; jtag_tdo/jtag_tdo_en are registered one TCK behind the shift state.
// Backpressure: none; the serial protocol is paced purely by TCK/TMS. Define JTAG_TAP_STROBE_CHECK_EN for simulation-only strobe/IR checks.
module jtag_tap_ctrl #(
    parameter int          IR_WIDTH     = 5,
    parameter int          NUM_CHAINS   = 4,
    parameter int          CHAIN_BASE   = 16,
    parameter int          IDCODE_INST  = 1,
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  jtag_tms,
    input  logic                  jtag_tdi,
    output logic                  jtag_tdo,
    output logic                  jtag_tdo_en,
    output logic                  chain_data,
    output logic [NUM_CHAINS-1:0] chain_capture,
    output logic [NUM_CHAINS-1:0] chain_shift,
    output logic [NUM_CHAINS-1:0] chain_update,
    input  logic [NUM_CHAINS-1:0] chain_out,
    output logic [IR_WIDTH-1:0]   ir_active,
    output logic                  tap_in_reset
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(IDCODE_INST);
    // Capture-IR pattern: LSBs 2'b01 as 1149.1 requires, upper bits zero.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    tap_state_t            state;
    tap_state_t            state_nxt;
    logic [IR_WIDTH-1:0]   ir_shift;
    logic [31:0]           idcode_shift;
    logic                  sel_idcode;
    logic [NUM_CHAINS-1:0] chain_sel;
    logic                  chain_tdo;

    // TAP state transition on TMS, straight from the 1149.1 state diagram.
    always_comb begin
        state_nxt = state;
        case (state)
            TLR:        state_nxt = jtag_tms ? TLR       : RTI;
            RTI:        state_nxt = jtag_tms ? SELECT_DR : RTI;
            SELECT_DR:  state_nxt = jtag_tms ? SELECT_IR : CAPTURE_DR;
            CAPTURE_DR: state_nxt = jtag_tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:   state_nxt = jtag_tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:   state_nxt = jtag_tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:   state_nxt = jtag_tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:   state_nxt = jtag_tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR:  state_nxt = jtag_tms ? SELECT_DR : RTI;
            SELECT_IR:  state_nxt = jtag_tms ? TLR       : CAPTURE_IR;
            CAPTURE_IR: state_nxt = jtag_tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:   state_nxt = jtag_tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:   state_nxt = jtag_tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:   state_nxt = jtag_tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:   state_nxt = jtag_tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR:  state_nxt = jtag_tms ? SELECT_DR : RTI;
            default:    state_nxt = TLR;
        endcase
    end

    assign sel_idcode = (ir_active == IR_IDCODE);

    // Instruction decode: one-hot chain select; unknown opcodes fall back to bypass (chain 0), IDCODE selects none.
    always_comb begin
        chain_sel = '0;
        if (!sel_idcode) begin
            for (int i = 1; i < NUM_CHAINS; i++) begin
                if (ir_active == IR_WIDTH'(CHAIN_BASE + i)) begin
                    chain_sel[i] = 1'b1;
                end
            end
            if (chain_sel == '0) begin
                chain_sel[0] = 1'b1;
            end
        end
    end

    assign chain_tdo     = |(chain_out & chain_sel);
    assign chain_data    = jtag_tdi;
    assign tap_in_reset  = (state == TLR);
    assign chain_capture = (state == CAPTURE_DR) ? chain_sel : '0;
    assign chain_shift   = (state == SHIFT_DR)   ? chain_sel : '0;
    assign chain_update  = (state == UPDATE_DR)  ? chain_sel : '0;

    // TAP state, IR/IDCODE shift registers and registered TDO; every update keys off the pre-edge state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= TLR;
            ir_active    <= IR_IDCODE;
            ir_shift     <= '0;
            idcode_shift <= IDCODE_VALUE;
            jtag_tdo     <= 1'b0;
            jtag_tdo_en  <= 1'b0;
        end else begin
            state       <= state_nxt;
            jtag_tdo_en <= 1'b0;
            case (state)
                CAPTURE_IR: ir_shift <= IR_CAPTURE;
                SHIFT_IR: begin
                    ir_shift    <= {jtag_tdi, ir_shift[IR_WIDTH-1:1]};
                    jtag_tdo    <= ir_shift[0];
                    jtag_tdo_en <= 1'b1;
                end
                UPDATE_IR:  ir_active <= ir_shift;
                CAPTURE_DR: begin
                    if (sel_idcode) idcode_shift <= IDCODE_VALUE;
                end
                SHIFT_DR: begin
                    if (sel_idcode) idcode_shift <= {jtag_tdi, idcode_shift[31:1]};
                    jtag_tdo    <= sel_idcode ? idcode_shift[0] : chain_tdo;
                    jtag_tdo_en <= 1'b1;
                end
                default: ;
            endcase
            // Reaching Test-Logic-Reset through TMS restores the default instruction.
            if (state_nxt == TLR) begin
                ir_active <= IR_IDCODE;
            end
        end
    end

`ifdef JTAG_TAP_STROBE_CHECK_EN
    tap_state_t          chk_state;
    logic [IR_WIDTH-1:0] chk_ir;
    logic                chk_nxt_tlr;
    logic                chk_vld;

    // Simulation-only guard: strobe exclusivity and IR changes only out of Update-IR or into TLR.
    always_ff @(posedge clock) begin
        chk_state   <= state;
        chk_ir      <= ir_active;
        chk_nxt_tlr <= (state_nxt == TLR);
        chk_vld     <= reset;
        if (reset) begin
            if (((|chain_capture) && (|chain_shift)) || ((|chain_capture) && (|chain_update)) ||
                ((|chain_shift) && (|chain_update))) begin
                $error("jtag_tap_ctrl: capture/shift/update strobes overlap");
                $fatal(1, "jtag_tap_ctrl: strobe check");
            end
            if (!$onehot0(chain_capture) || !$onehot0(chain_shift) || !$onehot0(chain_update)) begin
                $error("jtag_tap_ctrl: strobe vector not zero-or-one-hot");
                $fatal(1, "jtag_tap_ctrl: strobe check");
            end
            if (chk_vld && (ir_active != chk_ir) && !((chk_state == UPDATE_IR) || chk_nxt_tlr)) begin
                $error("jtag_tap_ctrl: ir_active changed outside Update-IR/TLR");
                $fatal(1, "jtag_tap_ctrl: ir check");
            end
        end
    end
`endif

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: vector table, directed corner sequences, randomized run vs. a reference model.
// Latency: one step = drive inputs at negedge, clock edge, compare at the following negedge.
// Backpressure: none.
module tb_jtag_tap_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       jtag_tms, jtag_tdi, jtag_tdo, jtag_tdo_en, chain_data, tap_in_reset;
    logic [3:0] chain_capture, chain_shift, chain_update, chain_out;
    logic [4:0] ir_active;

    always #5 clock = ~clock;

    jtag_tap_ctrl #(
        .IR_WIDTH(5), .NUM_CHAINS(4), .CHAIN_BASE(16), .IDCODE_INST(1), .IDCODE_VALUE(32'h0000_0001)
    ) dut (
        .clock(clock), .reset(reset), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
        .jtag_tdo(jtag_tdo), .jtag_tdo_en(jtag_tdo_en), .chain_data(chain_data),
        .chain_capture(chain_capture), .chain_shift(chain_shift), .chain_update(chain_update),
        .chain_out(chain_out), .ir_active(ir_active), .tap_in_reset(tap_in_reset)
    );

    localparam logic [31:0] IDV = 32'h0000_0001;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    // ---------------- reference model (named states, transition map) ----------------
    string      n0[string];
    string      n1[string];
    string      ms;
    logic [4:0] m_ir, m_irsr;
    logic [31:0] m_id;
    logic       m_tdo, m_en, m_tdi;

    task automatic arc(input string s, input string on0, input string on1);
        n0[s] = on0;
        n1[s] = on1;
    endtask

    function automatic int sel_idx(input logic [4:0] ir);
        if (ir >= 5'd17 && ir <= 5'd19) return int'(ir) - 16;
        return 0;
    endfunction

    function automatic logic [3:0] sel_vec(input logic [4:0] ir);
        logic [3:0] v;
        v = '0;
        if (ir != 5'd1) v[sel_idx(ir)] = 1'b1;
        return v;
    endfunction

    task automatic model_edge(input logic tms, input logic tdi, input logic rst_n, input logic [3:0] cout);
        string ps;
        logic  idsel;
        m_tdi = tdi;
        if (!rst_n) begin
            ms = "TLR"; m_ir = 5'd1; m_irsr = '0; m_id = IDV; m_tdo = 1'b0; m_en = 1'b0;
            return;
        end
        ps    = ms;
        idsel = (m_ir == 5'd1);
        ms    = tms ? n1[ps] : n0[ps];
        m_en  = 1'b0;
        if (ps == "SHIFT_IR") begin
            m_tdo = m_irsr[0]; m_en = 1'b1;
            m_irsr = {tdi, m_irsr[4:1]};
        end else if (ps == "CAP_IR") begin
            m_irsr = 5'b00001;
        end else if (ps == "UPD_IR") begin
            m_ir = m_irsr;
        end else if (ps == "SHIFT_DR") begin
            m_tdo = idsel ? m_id[0] : cout[sel_idx(m_ir)]; m_en = 1'b1;
            if (idsel) m_id = {tdi, m_id[31:1]};
        end else if (ps == "CAP_DR" && idsel) begin
            m_id = IDV;
        end
        if (ms == "TLR") m_ir = 5'd1;
    endtask

    task automatic check_model();
        chk("m.tap_in_reset", tap_in_reset, ms == "TLR");
        chk("m.tdo_en", jtag_tdo_en, m_en);
        chk("m.tdo", jtag_tdo, m_tdo);
        chk("m.ir_active", ir_active, m_ir);
        chk("m.chain_data", chain_data, m_tdi);
        chk("m.capture", chain_capture, (ms == "CAP_DR") ? sel_vec(m_ir) : 4'b0);
        chk("m.shift", chain_shift, (ms == "SHIFT_DR") ? sel_vec(m_ir) : 4'b0);
        chk("m.update", chain_update, (ms == "UPD_DR") ? sel_vec(m_ir) : 4'b0);
    endtask

    task automatic step(input logic tms, input logic tdi, input logic rst_n, input logic [3:0] cout);
        jtag_tms = tms; jtag_tdi = tdi; reset = rst_n; chain_out = cout;
        @(posedge clock);
        model_edge(tms, tdi, rst_n, cout);
        @(negedge clock);
        cyc++;
        check_model();
    endtask

    // From RTI: load an instruction and return to RTI.
    task automatic load_ir(input logic [4:0] val);
        step(1, 0, 1, 0); step(1, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
        for (int k = 0; k < 5; k++) step(k == 4, val[k], 1, 0);
        step(1, 0, 1, 0); step(0, 0, 1, 0);
        chk("load_ir.ir_active", ir_active, val);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic tms, tdi, rst_n; logic [3:0] cout;
        logic tir, en, tdo; logic [4:0] ir; logic [3:0] cap, sh, up;
    } vec_t;
    vec_t vt[20];

    logic [31:0] got;
    logic [3:0]  pat;
    logic [3:0]  rnd;
    logic        seen;

    initial begin
        arc("TLR", "RTI", "TLR");           arc("RTI", "RTI", "SEL_DR");
        arc("SEL_DR", "CAP_DR", "SEL_IR");  arc("CAP_DR", "SHIFT_DR", "EXIT1_DR");
        arc("SHIFT_DR", "SHIFT_DR", "EXIT1_DR"); arc("EXIT1_DR", "PAUSE_DR", "UPD_DR");
        arc("PAUSE_DR", "PAUSE_DR", "EXIT2_DR"); arc("EXIT2_DR", "SHIFT_DR", "UPD_DR");
        arc("UPD_DR", "RTI", "SEL_DR");     arc("SEL_IR", "CAP_IR", "TLR");
        arc("CAP_IR", "SHIFT_IR", "EXIT1_IR"); arc("SHIFT_IR", "SHIFT_IR", "EXIT1_IR");
        arc("EXIT1_IR", "PAUSE_IR", "UPD_IR"); arc("PAUSE_IR", "PAUSE_IR", "EXIT2_IR");
        arc("EXIT2_IR", "SHIFT_IR", "UPD_IR"); arc("UPD_IR", "RTI", "SEL_DR");
        ms = "TLR"; m_ir = 5'd1; m_irsr = '0; m_id = IDV; m_tdo = 1'b0; m_en = 1'b0; m_tdi = 1'b0;

        // reset, then IR <= 5'h1F (bypass), then one bypass DR scan with chain_out[0]=1
        //           tms   tdi   rst   cout     tir   en    tdo   ir      cap      sh       up
        vt[0]  = '{1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b0, 1'b0, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b0, 1'b0, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 4'h0,   1'b0, 1'b0, 1'b0, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 4'h0,   1'b0, 1'b0, 1'b0, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 4'h0,   1'b0, 1'b0, 1'b0, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 4'h0,   1'b0, 1'b0, 1'b0, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 4'h0,   1'b0, 1'b0, 1'b0, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 4'h0,   1'b0, 1'b1, 1'b1, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 4'h0,   1'b0, 1'b1, 1'b0, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 4'h0,   1'b0, 1'b1, 1'b0, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[10] = '{1'b0, 1'b1, 1'b1, 4'h0,   1'b0, 1'b1, 1'b0, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[11] = '{1'b1, 1'b1, 1'b1, 4'h0,   1'b0, 1'b1, 1'b0, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[12] = '{1'b1, 1'b0, 1'b1, 4'h0,   1'b0, 1'b0, 1'b0, 5'd1,  4'h0, 4'h0, 4'h0};
        vt[13] = '{1'b0, 1'b0, 1'b1, 4'h0,   1'b0, 1'b0, 1'b0, 5'd31, 4'h0, 4'h0, 4'h0};
        vt[14] = '{1'b1, 1'b0, 1'b1, 4'h0,   1'b0, 1'b0, 1'b0, 5'd31, 4'h0, 4'h0, 4'h0};
        vt[15] = '{1'b0, 1'b0, 1'b1, 4'h0,   1'b0, 1'b0, 1'b0, 5'd31, 4'h1, 4'h0, 4'h0};
        vt[16] = '{1'b0, 1'b0, 1'b1, 4'h0,   1'b0, 1'b0, 1'b0, 5'd31, 4'h0, 4'h1, 4'h0};
        vt[17] = '{1'b1, 1'b0, 1'b1, 4'h1,   1'b0, 1'b1, 1'b1, 5'd31, 4'h0, 4'h0, 4'h0};
        vt[18] = '{1'b1, 1'b0, 1'b1, 4'h0,   1'b0, 1'b0, 1'b1, 5'd31, 4'h0, 4'h0, 4'h1};
        vt[19] = '{1'b0, 1'b0, 1'b1, 4'h0,   1'b0, 1'b0, 1'b1, 5'd31, 4'h0, 4'h0, 4'h0};

        reset = 1'b0; jtag_tms = 1'b1; jtag_tdi = 1'b0; chain_out = '0;
        @(negedge clock);

        for (int i = 0; i < 20; i++) begin
            step(vt[i].tms, vt[i].tdi, vt[i].rst_n, vt[i].cout);
            chk("T.tap_in_reset", tap_in_reset, vt[i].tir);
            chk("T.tdo_en", jtag_tdo_en, vt[i].en);
            chk("T.tdo", jtag_tdo, vt[i].tdo);
            chk("T.ir_active", ir_active, vt[i].ir);
            chk("T.capture", chain_capture, vt[i].cap);
            chk("T.shift", chain_shift, vt[i].sh);
            chk("T.update", chain_update, vt[i].up);
        end

        // IDCODE scan: 32 shifts with TDI=0, LSB first
        step(0, 0, 0, 0); step(0, 0, 1, 0);
        chk("A.ir_after_reset", ir_active, 5'd1);
        step(1, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
        got = '0; seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step(i == 31, 0, 1, 4'hF);
            got[i] = jtag_tdo;
            seen |= |{chain_capture, chain_shift, chain_update};
        end
        chk("A.idcode_stream", got, IDV);
        chk("A.no_strobes", seen, 1'b0);
        step(1, 0, 1, 0); step(0, 0, 1, 0);

        // Five TMS=1 mid Shift-DR with IDCODE selected: no update strobe
        step(1, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
        step(0, 1, 1, 0); step(0, 0, 1, 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0);
            seen |= |chain_update;
        end
        chk("A2.in_tlr", tap_in_reset, 1'b1);
        chk("A2.no_update", seen, 1'b0);
        chk("A2.ir", ir_active, 5'd1);
        step(0, 0, 1, 0);

        // Chain 2 via IR=5'h12, chain_out[2] pattern 1,0,1,1
        load_ir(5'h12);
        step(1, 0, 1, 0); step(0, 0, 1, 0);
        chk("B.capture", chain_capture, 4'b0100);
        step(0, 0, 1, 0);
        chk("B.shift", chain_shift, 4'b0100);
        pat = 4'b1101; got = '0;
        for (int k = 0; k < 4; k++) begin
            rnd = 4'($urandom);
            rnd[2] = pat[k];
            step(k == 3, 0, 1, rnd);
            got[k] = jtag_tdo;
        end
        chk("B.tdo_stream", got, {28'd0, pat});
        step(1, 0, 1, 0);
        chk("B.update", chain_update, 4'b0100);
        step(0, 0, 1, 0);

        // Chain 2 selected, TMS-reset from Shift-DR restores IDCODE instruction
        step(1, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 1, 1, 4'h4);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
        chk("B2.in_tlr", tap_in_reset, 1'b1);
        chk("B2.ir", ir_active, 5'd1);
        step(0, 0, 1, 0);

        // Reset pulse mid Shift-IR
        load_ir(5'h13);
        step(1, 0, 1, 0); step(1, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
        step(0, 1, 1, 0); step(0, 1, 1, 0);
        chk("D.tdo_en_shifting", jtag_tdo_en, 1'b1);
        step(0, 1, 0, 0);
        chk("D.in_tlr", tap_in_reset, 1'b1);
        chk("D.ir", ir_active, 5'd1);
        chk("D.tdo_en", jtag_tdo_en, 1'b0);
        step(1, 0, 1, 0);
        chk("D.tdo_en_next", jtag_tdo_en, 1'b0);
        chk("D.still_tlr", tap_in_reset, 1'b1);

        // Randomized run against the model
        step(0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) < 35, 1'($urandom), $urandom_range(0, 299) != 0, 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller for the debug JTAG path.
- Runs the 16-state TAP FSM from TMS, holds the instruction register (IR) and decodes it into a one-hot chain select.
- Drives mutually exclusive capture/shift/update strobes into the selected external data-register chain (bypass chain, DTM chains) and muxes the chain outputs back to TDO.
- Contains the built-in 32-bit IDCODE data register.

Parameters:
- IR_WIDTH, 5: instruction register width, minimum 2.
- NUM_CHAINS, 4: number of external DR chains. Chain 0 is the bypass chain by convention.
- CHAIN_BASE, 16: IR value CHAIN_BASE+i selects external chain i, for i in 1..NUM_CHAINS-1.
- IDCODE_INST, 1: IR value selecting the internal IDCODE register. This is also the IR reset value.
- IDCODE_VALUE, 32'h00000001: IDCODE contents. Bit 0 must be 1.

Ports:
- clock  in  1  TCK-domain clock.
- reset  in  1  Synchronous, active-low.
- jtag_tms  in  1  Test mode select, sampled on the rising edge.
- jtag_tdi  in  1  Test data in.
- jtag_tdo  out  1  Registered test data out.
- jtag_tdo_en  out  1  High while TDO carries valid shift data.
- chain_data  out  1  Copy of jtag_tdi, broadcast to all chains.
- chain_capture  out  NUM_CHAINS  Per-chain capture strobe.
- chain_shift  out  NUM_CHAINS  Per-chain shift strobe.
- chain_update  out  NUM_CHAINS  Per-chain update strobe.
- chain_out  in  NUM_CHAINS  Serial output of each chain.
- ir_active  out  IR_WIDTH  Currently active instruction.
- tap_in_reset  out  1  High in Test-Logic-Reset.

Behaviour:
- Reset: reset is synchronous, active-low; clock is clock. On a clock edge with reset=0:
  - state=Test-Logic-Reset (TLR); ir_active=IDCODE_INST; IR shift register=0; IDCODE shift register=IDCODE_VALUE.
  - jtag_tdo=0, jtag_tdo_en=0, all strobes 0, tap_in_reset=1.
  - Reset asserted mid-shift aborts the shift; no update strobe is issued.
- FSM: standard 16 states, one transition per clock on TMS per IEEE 1149.1.
  - TLR: TMS=0 goes to Run-Test-Idle; TMS=1 stays.
  - Five consecutive TMS=1 reach TLR from any state.
  - Entering TLR by TMS also loads ir_active=IDCODE_INST.
- Decode of ir_active, held constant except at Update-IR:
  - IDCODE_INST: internal IDCODE register.
  - CHAIN_BASE+i, i in 1..NUM_CHAINS-1: chain i.
  - Any other value, including all-ones: chain 0 (bypass).
- DR strobes are combinational from the current state and asserted only for the selected external chain; all zero when IDCODE is selected.
  - Capture-DR: chain_capture[sel]=1.
  - Shift-DR: chain_shift[sel]=1.
  - Update-DR: chain_update[sel]=1.
  - At most one strobe bit is high in any cycle.
- IDCODE register:
  - Capture-DR loads IDCODE_VALUE.
  - Each Shift-DR edge shifts right, with jtag_tdi entering the MSB.
- IR path:
  - Capture-IR loads the IR shift register with {0..0,2'b01}.
  - Shift-IR shifts right, with TDI entering the MSB.
  - Update-IR copies the shift register to ir_active.
  - Exit to Update-IR without any shift commits the 2'b01 pattern; this is required behaviour.
- TDO is registered, with one cycle of latency from the state:
  - Shift-IR: next jtag_tdo = IR shift LSB.
  - Shift-DR: next jtag_tdo = IDCODE LSB or chain_out[sel].
  - jtag_tdo_en follows the same registered timing, high exactly in cycles after a Shift-IR/Shift-DR state.
  - Outside shift states, jtag_tdo holds its last value and jtag_tdo_en=0.
- Pause-DR/Pause-IR: no strobes, shift registers hold, tdo_en=0.
- tap_in_reset = (state==TLR), combinational.

Optional Feature:
- Macro: JTAG_TAP_STROBE_CHECK_EN.
- When defined: simulation-only checks, sampled on every clock edge with reset=1, each failure raising $error then $fatal:
  - OR-reduced capture/shift/update are pairwise exclusive.
  - Each strobe vector is zero-or-one-hot.
  - ir_active changes only in cycles whose previous state was Update-IR or TLR.
- When undefined: no checks compiled; RTL behaviour identical.

Test Plan:
- Reset=0 for 2 cycles, then TMS=0 → state Run-Test-Idle, ir_active=1, tdo_en=0, all strobes 0.
- Default IDCODE_VALUE=32'h1, Capture-DR then 32 Shift-DR cycles with TDI=0 → TDO serial stream 1 followed by 31 zeros, LSB first; chain strobes stay 0.
- Shift IR=5'h1F, Update-IR, Capture-DR, 1 Shift-DR, Update-DR → ir_active=31; chain_capture=4'b0001, chain_shift=4'b0001, chain_update=4'b0001 in the respective cycles; TDO=chain_out[0] one cycle later.
- IR=5'h12 (chain 2), drive chain_out[2] with the pattern 1,0,1,1 → TDO=1,0,1,1 with 1-cycle lag; chain 2 strobes only.
- Mid Shift-DR, drive five TMS=1 → TLR; no chain_update strobe; ir_active=1.
- Mid Shift-IR, pulse reset=0 for 1 cycle → TLR; ir_active=1; tdo_en=0 next cycle.
